// File: rtl/toggle_monitor.sv
// toggle_monitor
// Switching-activity monitor for a WIDTH-bit bus. Each cycle the Hamming
// distance between the current and previous sample is added into a saturating
// accumulator. Every WINDOW counted transitions the window total is published
// on a valid/ready result port.
// Optional feature macro: TOGGLE_PEAK_EN adds the `peak` output. It carries the
// largest single-cycle toggle count seen in the published window.
module toggle_monitor #(
   parameter int WIDTH  = 32,
   parameter int WINDOW = 256,
   parameter int ACC_W  = 24
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [WIDTH-1:0]                 d,
   output logic [ACC_W-1:0]                 total,
   output logic                             valid,
   input  logic                             ready,
   output logic                             sat,
   output logic                             overrun
`ifdef TOGGLE_PEAK_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0]       peak
`endif
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   // A window shorter than two transitions has no meaningful boundary sharing.
   if (WINDOW < 2) begin : g_bad_window
      $error("toggle_monitor: WINDOW must be at least 2");
   end

   // Number of set bits in a WIDTH-bit word, 0..WIDTH.
   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   // Saturating add of a toggle count into the accumulator.
   // Bit ACC_W of the result flags that the sum clipped at all-ones.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [PC_W-1:0]  b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(b);
      if (s[ACC_W]) begin
         return {1'b1, {ACC_W{1'b1}}};
      end
      return {1'b0, s[ACC_W-1:0]};
   endfunction

   // Sample history and priming
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             primed_q, primed_d;

   // Window accumulation state
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_sat_q, win_sat_d;

   // Published result state
   logic [ACC_W-1:0] total_q, total_d;
   logic             valid_q, valid_d;
   logic             sat_q, sat_d;
   logic             overrun_q, overrun_d;

`ifdef TOGGLE_PEAK_EN
   logic [PC_W-1:0]  peak_run_q, peak_run_d;
   logic [PC_W-1:0]  peak_q, peak_d;
   logic [PC_W-1:0]  peak_new;
`endif

   // Combinational toggle count and accumulation
   logic [PC_W-1:0]  pc;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] sum;
   logic             sum_clip;
   logic             win_end;

   // Next-state logic: priming, counting, window close and handshake.
   always_comb begin
      pc       = popcount(d ^ prev_q);
      sum_ext  = sat_add(acc_q, pc);
      sum      = sum_ext[ACC_W-1:0];
      sum_clip = sum_ext[ACC_W];
      win_end  = primed_q && (cnt_q == CNT_LAST);

      prev_d    = d;
      primed_d  = 1'b1;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      win_sat_d = win_sat_q;
      total_d   = total_q;
      sat_d     = sat_q;
      overrun_d = overrun_q;

      // A held result is consumed whenever ready is seen with valid high;
      // a result landing on the same edge re-asserts valid below.
      valid_d   = valid_q & ~ready;

`ifdef TOGGLE_PEAK_EN
      peak_new   = (pc > peak_run_q) ? pc : peak_run_q;
      peak_run_d = peak_run_q;
      peak_d     = peak_q;
`else
      // Without peak tracking there is no per-window maximum to maintain.
`endif

      if (primed_q) begin
         if (win_end) begin
            total_d   = sum;
            sat_d     = win_sat_q | sum_clip;
            valid_d   = 1'b1;
            // Only an unconsumed result being replaced counts as an overrun.
            overrun_d = overrun_q | (valid_q & ~ready);
            acc_d     = '0;
            cnt_d     = '0;
            win_sat_d = 1'b0;
`ifdef TOGGLE_PEAK_EN
            peak_d     = peak_new;
            peak_run_d = '0;
`endif
         end else begin
            acc_d     = sum;
            cnt_d     = cnt_q + 1'b1;
            win_sat_d = win_sat_q | sum_clip;
`ifdef TOGGLE_PEAK_EN
            peak_run_d = peak_new;
`endif
         end
      end
   end

   // Previous-sample register; its content is irrelevant until primed.
   always_ff @(posedge clk) begin
      prev_q <= prev_d;
   end

   // Control and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         primed_q  <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         win_sat_q <= 1'b0;
         total_q   <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         primed_q  <= primed_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         win_sat_q <= win_sat_d;
         total_q   <= total_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef TOGGLE_PEAK_EN
   // Running and published peak registers, cleared with the rest of the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         peak_run_q <= '0;
         peak_q     <= '0;
      end else begin
         peak_run_q <= peak_run_d;
         peak_q     <= peak_d;
      end
   end

   assign peak = peak_q;
`endif

   assign total   = total_q;
   assign valid   = valid_q;
   assign sat     = sat_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Bench for toggle_monitor: two instances (long window with a narrow
// accumulator, short window with a wide one) share the same stimulus and are
// compared every cycle against a history-based reference model.
module tb_toggle_monitor;

   localparam int WIDTH = 32;
   localparam int WIN_A = 256;
   localparam int ACC_A = 12;
   localparam int WIN_B = 4;
   localparam int ACC_B = 24;
   localparam int PK_W  = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [WIDTH-1:0] d;
   logic             ready;

   logic [ACC_A-1:0] total_a;
   logic             valid_a, sat_a, ovr_a;
   logic [ACC_B-1:0] total_b;
   logic             valid_b, sat_b, ovr_b;
`ifdef TOGGLE_PEAK_EN
   logic [PK_W-1:0]  peak_a, peak_b;
`endif

   toggle_monitor #(.WIDTH(WIDTH), .WINDOW(WIN_A), .ACC_W(ACC_A)) dut_a (
      .clk(clk), .reset(rst_n), .d(d), .total(total_a), .valid(valid_a),
      .ready(ready), .sat(sat_a), .overrun(ovr_a)
`ifdef TOGGLE_PEAK_EN
      , .peak(peak_a)
`endif
   );

   toggle_monitor #(.WIDTH(WIDTH), .WINDOW(WIN_B), .ACC_W(ACC_B)) dut_b (
      .clk(clk), .reset(rst_n), .d(d), .total(total_b), .valid(valid_b),
      .ready(ready), .sat(sat_b), .overrun(ovr_b)
`ifdef TOGGLE_PEAK_EN
      , .peak(peak_b)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: toggle counts since the last priming, in order.
   int         hist[$];
   bit         primed = 1'b0;
   logic [31:0] last_d;
   int win[2]  = '{WIN_A, WIN_B};
   int maxv[2] = '{(1 << ACC_A) - 1, (1 << ACC_B) - 1};
   int e_total[2], e_valid[2], e_sat[2], e_ovr[2], e_peak[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit newres[2];
      int sum, pk, n;
      if (!rst_n) begin
         primed = 1'b0;
         hist.delete();
         for (int i = 0; i < 2; i++) begin
            e_total[i] = 0; e_valid[i] = 0; e_sat[i] = 0; e_ovr[i] = 0; e_peak[i] = 0;
         end
      end else begin
         newres = '{1'b0, 1'b0};
         if (!primed) begin
            primed = 1'b1;
            last_d = d;
         end else begin
            hist.push_back($countones(d ^ last_d));
            last_d = d;
            for (int i = 0; i < 2; i++)
               if (hist.size() % win[i] == 0) newres[i] = 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            if (newres[i]) begin
               sum = 0; pk = 0; n = hist.size();
               for (int k = n - win[i]; k < n; k++) begin
                  sum += hist[k];
                  if (hist[k] > pk) pk = hist[k];
               end
               e_total[i] = (sum > maxv[i]) ? maxv[i] : sum;
               e_sat[i]   = (sum > maxv[i]) ? 1 : 0;
               e_peak[i]  = pk;
               if (e_valid[i] != 0 && !ready) e_ovr[i] = 1;
               e_valid[i] = 1;
            end else if (e_valid[i] != 0 && ready) begin
               e_valid[i] = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("a_total", 32'(total_a), e_total[0]);
      check("a_valid", 32'(valid_a), e_valid[0]);
      check("a_sat",   32'(sat_a),   e_sat[0]);
      check("a_ovr",   32'(ovr_a),   e_ovr[0]);
      check("b_total", 32'(total_b), e_total[1]);
      check("b_valid", 32'(valid_b), e_valid[1]);
      check("b_sat",   32'(sat_b),   e_sat[1]);
      check("b_ovr",   32'(ovr_b),   e_ovr[1]);
`ifdef TOGGLE_PEAK_EN
      check("a_peak",  32'(peak_a),  e_peak[0]);
      check("b_peak",  32'(peak_b),  e_peak[1]);
`endif
   endtask

   // Apply inputs, take one rising edge, advance the model, check #1 later.
   task automatic step(input logic r, input logic [31:0] dv, input logic rdy);
      rst_n = r; d = dv; ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   function automatic logic [31:0] rnd_word();
      if ($urandom_range(0, 3) == 0) return $urandom();
      return $urandom() & $urandom() & $urandom();
   endfunction

   initial begin
      rst_n = 1'b0; d = '0; ready = 1'b0;
      #2;

      // Reset state
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      check("rst_total", 32'(total_a), 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);

      // Counter stream 0..256
      for (int k = 0; k <= 256; k++) step(1'b1, 32'(k), 1'b1);
      check("cs_valid", 32'(valid_a), 32'd1);
      check("cs_total", 32'(total_a), 32'd511);
      check("cs_sat",   32'(sat_a),   32'd0);
`ifdef TOGGLE_PEAK_EN
      check("cs_peak",  32'(peak_a),  32'd9);
`endif
      step(1'b1, 32'd256, 1'b1);
      check("cs_consumed", 32'(valid_a), 32'd0);

      // Constant input
      step(1'b0, 32'h0, 1'b1);
      for (int k = 1; k <= 600; k++) begin
         step(1'b1, 32'hDEADBEEF, 1'b1);
         if (k == 257 || k == 513) begin
            check("const_valid", 32'(valid_a), 32'd1);
            check("const_total", 32'(total_a), 32'd0);
         end
      end

      // Alternating input, then constant: saturation and recovery
      step(1'b0, 32'h0, 1'b1);
      for (int k = 1; k <= 257; k++) begin
         step(1'b1, (k % 2 == 1) ? 32'h0 : 32'hFFFFFFFF, 1'b1);
         if (k == 9) begin
            check("alt_b_total", 32'(total_b), 32'd128);
`ifdef TOGGLE_PEAK_EN
            check("alt_b_peak", 32'(peak_b), 32'd32);
`endif
         end
      end
      check("sat_total", 32'(total_a), 32'd4095);
      check("sat_flag",  32'(sat_a),   32'd1);
      for (int k = 1; k <= 256; k++) step(1'b1, 32'h0, 1'b1);
      check("unsat_total", 32'(total_a), 32'd0);
      check("unsat_flag",  32'(sat_a),   32'd0);

      // Handshake: accept at a window end, then overrun, then consume, then reset
      step(1'b0, 32'h0, 1'b0);
      for (int e = 1; e <= 770; e++) begin
         step(1'b1, rnd_word(), (e == 513 || e == 770));
         if (e == 513) begin
            check("hs_edge_valid", 32'(valid_a), 32'd1);
            check("hs_edge_ovr",   32'(ovr_a),   32'd0);
         end
         if (e == 769) begin
            check("hs_ovr_set",   32'(ovr_a),   32'd1);
            check("hs_ovr_valid", 32'(valid_a), 32'd1);
         end
      end
      check("hs_drop", 32'(valid_a), 32'd0);
      step(1'b0, 32'h0, 1'b0);
      check("hs_rst_ovr", 32'(ovr_a), 32'd0);

      // Reset mid-window
      for (int e = 1; e <= 101; e++) step(1'b1, rnd_word(), 1'b1);
      step(1'b0, rnd_word(), 1'b1);
      check("mid_valid", 32'(valid_a), 32'd0);
      check("mid_total", 32'(total_a), 32'd0);
      for (int e = 1; e <= 257; e++) step(1'b1, rnd_word(), 1'b1);
      check("mid_fresh_valid", 32'(valid_a), 32'd1);

      // Random traffic with random ready and occasional reset
      for (int e = 0; e < 1500; e++)
         step(($urandom_range(0, 399) != 0), rnd_word(), 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
